uart_rx: RTL and testbench
==========================

// Module: uart_rx
// PURPOSE
// - UART receiver. Consumes the oversample clock from the baud generator (OVERSAMPLING edges per bit).
// - Recovers 8N1 frames (optional parity) from rx_in and presents each byte with a one-cycle valid strobe.
// - Sits between the pad-side serial line and the byte-level consumer. All logic runs on clk_in.
// PARAMETERS
// - DATA_BITS     8  data bits per frame, LSB first.
// - OVERSAMPLING  8  oversample edges per bit; even, >= 4; must match the baud generator.
// - PARITY_EN     0  1 = one parity bit between the data bits and the stop bit.
// - PARITY_ODD    0  0 = even parity, 1 = odd parity; ignored when PARITY_EN = 0.
// PORTS
// - clk_in          in   1          system clock
// - nrst_in         in   1          synchronous reset, active-low
// - os_clk_in       in   1          oversample clock from the baud generator; level signal in the clk_in domain
// - rx_in           in   1          serial line, asynchronous, idle high
// - data_out        out  DATA_BITS  last received byte; held until the next frame completes
// - valid_out       out  1          1-cycle pulse when data_out/err flags update
// - frame_err_out   out  1          stop bit sampled 0; valid with valid_out, held until next frame
// - parity_err_out  out  1          parity mismatch; valid with valid_out, held until next frame
// - busy_out        out  1          1 while the FSM is not IDLE
// BEHAVIOUR
// - Reset (nrst_in = 0 at a clk_in edge):
//   - FSM -> IDLE; counters -> 0.
//   - data_out, valid_out, frame_err_out, parity_err_out, busy_out -> 0.
//   - Both rx synchroniser flops -> 1. os_clk previous-value flop -> 1, so a high os_clk after reset makes no tick.
//   - Reset wins over a simultaneous tick or rx edge.
// - Reset mid-frame aborts the frame silently: no valid_out, outputs cleared.
// - Tick:
//   - 1-cycle internal pulse on each 0->1 transition of os_clk_in (registered edge detect).
//   - All FSM advancement happens only on tick cycles.
// - rx_s: rx_in after a 2-flop synchroniser.
// - os_cnt: width $clog2(OVERSAMPLING); counts ticks within a bit; wraps to 0 at each bit boundary.
// - States:
//   - IDLE:   on a tick with rx_s = 0 and armed = 1 -> START, os_cnt = 0.
//   - START:  on each tick os_cnt++. When os_cnt reaches OVERSAMPLING/2 - 1, sample rx_s:
//             0 -> DATA, os_cnt = 0, bit_cnt = 0; 1 -> IDLE (false start, no output change).
//   - DATA:   on each tick os_cnt++. At os_cnt = OVERSAMPLING-1: shift rx_s in at the MSB of the shift register
//             (LSB first on the wire), os_cnt = 0, bit_cnt++. After DATA_BITS samples -> PARITY if PARITY_EN, else STOP.
//   - PARITY: sample at os_cnt = OVERSAMPLING-1. Store mismatch = (XOR of data ^ sample) != PARITY_ODD. -> STOP.
//   - STOP:   sample at os_cnt = OVERSAMPLING-1.
//             - Next clk_in cycle: data_out <= shift register, frame_err_out <= ~sample,
//               parity_err_out <= stored mismatch (0 if !PARITY_EN), valid_out = 1 for one cycle.
//             - FSM -> IDLE.
// - armed: cleared when a frame ends with a frame error; set when rx_s = 1 on a tick.
//   A break (line held low) therefore yields exactly one frame_err frame, then waits for idle-high.
// - Latency: valid_out asserts 1 clk_in cycle after the tick at which the stop bit is sampled.
// - Back-to-back frames: a start bit immediately after the stop-bit sample is accepted.
//   IDLE checks rx_s on the very next tick.
// - busy_out is 1 in START/DATA/PARITY/STOP and 0 in IDLE; it is registered with the state.
// STRUCTURE
// - Shared package uart_pkg: FSM state encoding (IDLE, START, DATA, PARITY, STOP);
//   default OVERSAMPLING and DATA_BITS constants shared with the baud generator and the future uart_tx.
// - One sub-module: os_tick_detect (clk_in, nrst_in, os_clk_in -> tick_out), the registered rising-edge detector.
//   It is reused by uart_tx.
// - Synchroniser, FSM, counters, shift register and output registers stay in uart_rx.
// TESTING
// - Setup: os_clk_in period = 8 clk_in (OVERSAMPLING = 8), so 1 bit = 64 clk_in cycles. Defaults unless stated.
// - Frame 0x55, stop = 1 -> one valid_out pulse, data_out = 0x55, frame_err_out = 0, parity_err_out = 0, busy_out falls.
// - rx_in low for 2 ticks, then high -> no valid_out, busy_out returns to 0, data_out unchanged.
// - Frame 0xA3 with stop bit 0 -> valid_out, data_out = 0xA3, frame_err_out = 1.
//   - Line stays low 3 more bit times -> no further valid_out until rx_in has returned high.
// - PARITY_EN = 1, even parity: 0x07 with parity bit 0 -> parity_err_out = 1.
//   - 0x07 with parity bit 1 -> parity_err_out = 0.
// - nrst_in low for 1 cycle after 3 data bits of 0xFF -> all outputs 0, no valid.
//   - Next frame 0x3C -> data_out = 0x3C.
// - Back-to-back 0x00 then 0xFF with no idle gap -> two valid_out pulses 640 clk_in cycles apart, both flags 0.

Source files
------------

// File: rtl/uart_pkg.sv
// uart_pkg: shared FSM encoding and default frame constants for the UART blocks
package uart_pkg;
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
    localparam int DEF_OVERSAMPLING = 8;
    localparam int DEF_DATA_BITS    = 8;
endpackage

// File: rtl/os_tick_detect.sv
// os_tick_detect: registered rising-edge detector turning the oversample level into a one-cycle tick
module os_tick_detect (
    input  logic clk_in,
    input  logic nrst_in,
    input  logic os_clk_in,
    output logic tick_out
);
    logic r_prev;
    logic r_tick;
    // previous level resets high so an already-high os_clk after reset produces no tick
    always_ff @(posedge clk_in) begin
        if (!nrst_in) begin
            r_prev <= 1'b1;
            r_tick <= 1'b0;
        end else begin
            r_prev <= os_clk_in;
            r_tick <= os_clk_in & ~r_prev;
        end
    end
    assign tick_out = r_tick;
endmodule

// File: rtl/uart_rx.sv
// uart_rx: oversampled UART receiver recovering 8N1 (optional parity) frames into bytes
module uart_rx
    import uart_pkg::*;
#(
    parameter int DATA_BITS    = DEF_DATA_BITS,
    parameter int OVERSAMPLING = DEF_OVERSAMPLING,
    parameter int PARITY_EN    = 0,
    parameter int PARITY_ODD   = 0
) (
    input  logic                 clk_in,
    input  logic                 nrst_in,
    input  logic                 os_clk_in,
    input  logic                 rx_in,
    output logic [DATA_BITS-1:0] data_out,
    output logic                 valid_out,
    output logic                 frame_err_out,
    output logic                 parity_err_out,
    output logic                 busy_out
);
    localparam int CW = $clog2(OVERSAMPLING);
    localparam int BW = $clog2(DATA_BITS + 1);
    localparam logic [CW-1:0] OS_LAST = CW'(OVERSAMPLING - 1);
    localparam logic [CW-1:0] OS_HALF = CW'(OVERSAMPLING / 2 - 1);
    localparam logic [BW-1:0] BIT_LAST = BW'(DATA_BITS - 1);
    logic                 w_tick;
    logic                 w_at_last;
    logic                 w_at_half;
    state_t               w_next;
    state_t               r_state;
    logic                 r_rx_meta;
    logic                 r_rx_s;
    logic [CW-1:0]        r_os_cnt;
    logic [BW-1:0]        r_bit_cnt;
    logic [DATA_BITS-1:0] r_shift;
    logic                 r_par_err;
    logic                 r_armed;
    logic [DATA_BITS-1:0] r_data;
    logic                 r_valid;
    logic                 r_ferr;
    logic                 r_perr;
    logic                 r_busy;

    os_tick_detect u_tick (
        .clk_in   (clk_in),
        .nrst_in  (nrst_in),
        .os_clk_in(os_clk_in),
        .tick_out (w_tick)
    );

    assign w_at_last = r_os_cnt == OS_LAST;
    assign w_at_half = r_os_cnt == OS_HALF;

    // next-state decode; the FSM only moves on oversample ticks
    always_comb begin
        w_next = r_state;
        if (w_tick) begin
            case (r_state)
                IDLE:    w_next = (!r_rx_s && r_armed) ? START : IDLE;
                START:   w_next = w_at_half ? (r_rx_s ? IDLE : DATA) : START;
                DATA:    w_next = (w_at_last && r_bit_cnt == BIT_LAST) ? (PARITY_EN != 0 ? PARITY : STOP) : DATA;
                PARITY:  w_next = w_at_last ? STOP : PARITY;
                STOP:    w_next = w_at_last ? IDLE : STOP;
                default: w_next = IDLE;
            endcase
        end
    end

    // synchroniser, state, counters, shift register and registered outputs
    always_ff @(posedge clk_in) begin
        if (!nrst_in) begin
            r_rx_meta <= 1'b1;
            r_rx_s    <= 1'b1;
            r_state   <= IDLE;
            r_os_cnt  <= '0;
            r_bit_cnt <= '0;
            r_shift   <= '0;
            r_par_err <= 1'b0;
            r_armed   <= 1'b1;
            r_data    <= '0;
            r_valid   <= 1'b0;
            r_ferr    <= 1'b0;
            r_perr    <= 1'b0;
            r_busy    <= 1'b0;
        end else begin
            r_rx_meta <= rx_in;
            r_rx_s    <= r_rx_meta;
            r_state   <= w_next;
            r_busy    <= w_next != IDLE;
            r_valid   <= 1'b0;
            if (w_tick) begin
                if (r_rx_s) r_armed <= 1'b1;
                case (r_state)
                    IDLE: r_os_cnt <= '0;
                    START: begin
                        r_os_cnt <= w_at_half ? '0 : r_os_cnt + 1'b1;
                        if (w_at_half) r_bit_cnt <= '0;
                    end
                    default: begin
                        r_os_cnt <= w_at_last ? '0 : r_os_cnt + 1'b1;
                        if (w_at_last && r_state == DATA) begin
                            r_shift   <= {r_rx_s, r_shift[DATA_BITS-1:1]};
                            r_bit_cnt <= r_bit_cnt + 1'b1;
                        end
                        if (w_at_last && r_state == PARITY) r_par_err <= (^r_shift ^ r_rx_s) != PARITY_ODD[0];
                        if (w_at_last && r_state == STOP) begin
                            r_data  <= r_shift;
                            r_ferr  <= ~r_rx_s;
                            r_perr  <= (PARITY_EN != 0) && r_par_err;
                            r_valid <= 1'b1;
                            if (!r_rx_s) r_armed <= 1'b0;
                        end
                    end
                endcase
            end
        end
    end

    assign data_out       = r_data;
    assign valid_out      = r_valid;
    assign frame_err_out  = r_ferr;
    assign parity_err_out = r_perr;
    assign busy_out       = r_busy;
endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed scenarios for uart_rx with and without parity
module tb_uart_rx;
    logic       clk = 1'b0;
    logic       nrst = 1'b0;
    logic       os_clk = 1'b0;
    logic       rx = 1'b1;
    logic       rx_p = 1'b1;
    logic [2:0] os_div = '0;
    logic [7:0] data, data_p;
    logic       valid, valid_p, fe, fe_p, pe, pe_p, busy, busy_p;
    int         n_checks = 0;
    int         n_fail = 0;
    int         cyc = 0;
    int         nv = 0;
    int         nv_p = 0;
    int         t_last = 0;
    int         t_prev = 0;
    logic [7:0] d_last = '0;
    logic [7:0] d_prev = '0;

    uart_rx u_dut (
        .clk_in(clk), .nrst_in(nrst), .os_clk_in(os_clk), .rx_in(rx),
        .data_out(data), .valid_out(valid), .frame_err_out(fe),
        .parity_err_out(pe), .busy_out(busy)
    );

    uart_rx #(.PARITY_EN(1), .PARITY_ODD(0)) u_par (
        .clk_in(clk), .nrst_in(nrst), .os_clk_in(os_clk), .rx_in(rx_p),
        .data_out(data_p), .valid_out(valid_p), .frame_err_out(fe_p),
        .parity_err_out(pe_p), .busy_out(busy_p)
    );

    always #5 clk = ~clk;

    // oversample clock: 8 clk periods, 50% duty
    always @(posedge clk) begin
        cyc    <= cyc + 1;
        os_div <= os_div + 1'b1;
        os_clk <= os_div[2];
    end

    // record every valid pulse of the default instance
    always @(posedge clk) begin
        if (valid) begin
            nv     <= nv + 1;
            t_prev <= t_last;
            t_last <= cyc;
            d_prev <= d_last;
            d_last <= data;
        end
    end

    // count valid pulses of the parity instance
    always @(posedge clk) begin
        if (valid_p) nv_p <= nv_p + 1;
    end

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drive_bit(input bit line, input bit b);
        if (line) rx_p = b;
        else rx = b;
        wait_cyc(64);
    endtask

    task automatic send(input bit line, input logic [7:0] d, input bit use_par, input bit par, input bit stop);
        drive_bit(line, 1'b0);
        for (int i = 0; i < 8; i++) drive_bit(line, d[i]);
        if (use_par) drive_bit(line, par);
        drive_bit(line, stop);
    endtask

    task automatic test_reset;
        nrst = 1'b0;
        wait_cyc(4);
        n_checks += 6;
        if (data !== 8'h00) begin n_fail++; $display("FAIL reset_data got %h want 00", data); end
        if (valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b want 0", valid); end
        if (fe !== 1'b0) begin n_fail++; $display("FAIL reset_ferr got %b want 0", fe); end
        if (pe !== 1'b0) begin n_fail++; $display("FAIL reset_perr got %b want 0", pe); end
        if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", busy); end
        if (busy_p !== 1'b0) begin n_fail++; $display("FAIL reset_busy_par got %b want 0", busy_p); end
        nrst = 1'b1;
        wait_cyc(32);
        n_checks += 2;
        if (nv !== 0) begin n_fail++; $display("FAIL idle_no_valid got %0d want 0", nv); end
        if (busy !== 1'b0) begin n_fail++; $display("FAIL idle_busy got %b want 0", busy); end
    endtask

    task automatic test_basic;
        int n0;
        n0 = nv;
        send(1'b0, 8'h55, 1'b0, 1'b0, 1'b1);
        wait_cyc(32);
        n_checks += 5;
        if (nv !== n0 + 1) begin n_fail++; $display("FAIL basic_count got %0d want %0d", nv, n0 + 1); end
        if (data !== 8'h55) begin n_fail++; $display("FAIL basic_data got %h want 55", data); end
        if (fe !== 1'b0) begin n_fail++; $display("FAIL basic_ferr got %b want 0", fe); end
        if (pe !== 1'b0) begin n_fail++; $display("FAIL basic_perr got %b want 0", pe); end
        if (busy !== 1'b0) begin n_fail++; $display("FAIL basic_busy got %b want 0", busy); end
    endtask

    task automatic test_false_start;
        int n0;
        n0 = nv;
        rx = 1'b0;
        wait_cyc(16);
        n_checks++;
        if (busy !== 1'b1) begin n_fail++; $display("FAIL false_start_busy_hi got %b want 1", busy); end
        rx = 1'b1;
        wait_cyc(128);
        n_checks += 3;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL false_start_busy_lo got %b want 0", busy); end
        if (nv !== n0) begin n_fail++; $display("FAIL false_start_count got %0d want %0d", nv, n0); end
        if (data !== 8'h55) begin n_fail++; $display("FAIL false_start_data got %h want 55", data); end
    endtask

    task automatic test_frame_err;
        int n0;
        n0 = nv;
        send(1'b0, 8'hA3, 1'b0, 1'b0, 1'b0);
        n_checks += 4;
        if (nv !== n0 + 1) begin n_fail++; $display("FAIL ferr_count got %0d want %0d", nv, n0 + 1); end
        if (data !== 8'hA3) begin n_fail++; $display("FAIL ferr_data got %h want a3", data); end
        if (fe !== 1'b1) begin n_fail++; $display("FAIL ferr_flag got %b want 1", fe); end
        if (pe !== 1'b0) begin n_fail++; $display("FAIL ferr_perr got %b want 0", pe); end
        wait_cyc(192);
        n_checks += 2;
        if (nv !== n0 + 1) begin n_fail++; $display("FAIL break_count got %0d want %0d", nv, n0 + 1); end
        if (busy !== 1'b0) begin n_fail++; $display("FAIL break_busy got %b want 0", busy); end
        rx = 1'b1;
        wait_cyc(128);
        send(1'b0, 8'h55, 1'b0, 1'b0, 1'b1);
        wait_cyc(32);
        n_checks += 3;
        if (nv !== n0 + 2) begin n_fail++; $display("FAIL rearm_count got %0d want %0d", nv, n0 + 2); end
        if (fe !== 1'b0) begin n_fail++; $display("FAIL rearm_ferr got %b want 0", fe); end
        if (data !== 8'h55) begin n_fail++; $display("FAIL rearm_data got %h want 55", data); end
    endtask

    task automatic test_parity;
        int n0;
        n0 = nv_p;
        send(1'b1, 8'h07, 1'b1, 1'b0, 1'b1);
        wait_cyc(32);
        n_checks += 4;
        if (nv_p !== n0 + 1) begin n_fail++; $display("FAIL par_bad_count got %0d want %0d", nv_p, n0 + 1); end
        if (data_p !== 8'h07) begin n_fail++; $display("FAIL par_bad_data got %h want 07", data_p); end
        if (pe_p !== 1'b1) begin n_fail++; $display("FAIL par_bad_perr got %b want 1", pe_p); end
        if (fe_p !== 1'b0) begin n_fail++; $display("FAIL par_bad_ferr got %b want 0", fe_p); end
        send(1'b1, 8'h07, 1'b1, 1'b1, 1'b1);
        wait_cyc(32);
        n_checks += 3;
        if (nv_p !== n0 + 2) begin n_fail++; $display("FAIL par_ok_count got %0d want %0d", nv_p, n0 + 2); end
        if (data_p !== 8'h07) begin n_fail++; $display("FAIL par_ok_data got %h want 07", data_p); end
        if (pe_p !== 1'b0) begin n_fail++; $display("FAIL par_ok_perr got %b want 0", pe_p); end
    endtask

    task automatic test_reset_mid;
        int n0;
        n0 = nv;
        rx = 1'b0;
        wait_cyc(64);
        rx = 1'b1;
        wait_cyc(192);
        n_checks++;
        if (busy !== 1'b1) begin n_fail++; $display("FAIL mid_busy_before got %b want 1", busy); end
        nrst = 1'b0;
        wait_cyc(1);
        n_checks += 5;
        if (data !== 8'h00) begin n_fail++; $display("FAIL mid_rst_data got %h want 00", data); end
        if (valid !== 1'b0) begin n_fail++; $display("FAIL mid_rst_valid got %b want 0", valid); end
        if (fe !== 1'b0) begin n_fail++; $display("FAIL mid_rst_ferr got %b want 0", fe); end
        if (pe !== 1'b0) begin n_fail++; $display("FAIL mid_rst_perr got %b want 0", pe); end
        if (busy !== 1'b0) begin n_fail++; $display("FAIL mid_rst_busy got %b want 0", busy); end
        nrst = 1'b1;
        wait_cyc(384);
        n_checks += 2;
        if (nv !== n0) begin n_fail++; $display("FAIL mid_no_valid got %0d want %0d", nv, n0); end
        if (busy !== 1'b0) begin n_fail++; $display("FAIL mid_idle_busy got %b want 0", busy); end
        send(1'b0, 8'h3C, 1'b0, 1'b0, 1'b1);
        wait_cyc(32);
        n_checks += 3;
        if (nv !== n0 + 1) begin n_fail++; $display("FAIL mid_next_count got %0d want %0d", nv, n0 + 1); end
        if (data !== 8'h3C) begin n_fail++; $display("FAIL mid_next_data got %h want 3c", data); end
        if (fe !== 1'b0) begin n_fail++; $display("FAIL mid_next_ferr got %b want 0", fe); end
    endtask

    task automatic test_back_to_back;
        int n0;
        n0 = nv;
        send(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        send(1'b0, 8'hFF, 1'b0, 1'b0, 1'b1);
        wait_cyc(32);
        n_checks += 6;
        if (nv !== n0 + 2) begin n_fail++; $display("FAIL b2b_count got %0d want %0d", nv, n0 + 2); end
        if (t_last - t_prev !== 640) begin n_fail++; $display("FAIL b2b_spacing got %0d want 640", t_last - t_prev); end
        if (d_prev !== 8'h00) begin n_fail++; $display("FAIL b2b_first_data got %h want 00", d_prev); end
        if (d_last !== 8'hFF) begin n_fail++; $display("FAIL b2b_second_data got %h want ff", d_last); end
        if (fe !== 1'b0) begin n_fail++; $display("FAIL b2b_ferr got %b want 0", fe); end
        if (pe !== 1'b0) begin n_fail++; $display("FAIL b2b_perr got %b want 0", pe); end
    endtask

    initial begin
        test_reset;
        test_basic;
        test_false_start;
        test_frame_err;
        test_parity;
        test_reset_mid;
        test_back_to_back;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
